// File: rtl/div_issue_scheduler_if.sv
// Dispatch/divider-side signal bundle for div_issue_scheduler.
// The master modport is the dispatch/divider environment; the slave modport is the scheduler.
interface div_issue_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int SQN_W = 7,
  parameter int TAG_W = 7
);
  logic                     IN_valid;
  logic [SQN_W-1:0]         IN_sqN;
  logic [TAG_W-1:0]         IN_tagDst;
  logic [1:0]               IN_opcode;
  logic [31:0]              IN_srcA;
  logic [31:0]              IN_srcB;
  logic                     OUT_ready;
  logic                     IN_brTaken;
  logic [SQN_W-1:0]         IN_brSqN;
  logic                     IN_divBusy;
  logic                     OUT_issValid;
  logic [SQN_W-1:0]         OUT_issSqN;
  logic [TAG_W-1:0]         OUT_issTagDst;
  logic [1:0]               OUT_issOpcode;
  logic [31:0]              OUT_issSrcA;
  logic [31:0]              OUT_issSrcB;
  logic [$clog2(DEPTH):0]   OUT_count;

  modport master (
    output IN_valid, IN_sqN, IN_tagDst, IN_opcode, IN_srcA, IN_srcB,
    output IN_brTaken, IN_brSqN, IN_divBusy,
    input  OUT_ready, OUT_issValid, OUT_issSqN, OUT_issTagDst, OUT_issOpcode,
    input  OUT_issSrcA, OUT_issSrcB, OUT_count
  );

  modport slave (
    input  IN_valid, IN_sqN, IN_tagDst, IN_opcode, IN_srcA, IN_srcB,
    input  IN_brTaken, IN_brSqN, IN_divBusy,
    output OUT_ready, OUT_issValid, OUT_issSqN, OUT_issTagDst, OUT_issOpcode,
    output OUT_issSrcA, OUT_issSrcB, OUT_count
  );
endinterface

// File: rtl/div_issue_scheduler.sv
// Issue queue in front of the shared iterative divider: buffers uops, issues oldest-first
// when the divider is free, and squashes entries younger than a mispredicted branch.
module div_issue_scheduler #(
  parameter int DEPTH   = 4,
  parameter int SQN_W   = 7,
  parameter int TAG_W   = 7,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               rst,
  div_issue_scheduler_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int HW = $clog2(HOLDOFF + 2);

  typedef logic [SQN_W-1:0] sqn_t;

  // Wrap-around ordering: x is younger than base when the signed difference is positive.
  function automatic logic younger(input sqn_t x, input sqn_t base);
    logic signed [SQN_W-1:0] d;
    d = x - base;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  function automatic logic older(input sqn_t x, input sqn_t y);
    logic signed [SQN_W-1:0] d;
    d = x - y;
    return d[SQN_W-1];
  endfunction

  logic [DEPTH-1:0] ent_vld;
  sqn_t             ent_sqn [DEPTH];
  logic [TAG_W-1:0] ent_tag [DEPTH];
  logic [1:0]       ent_op  [DEPTH];
  logic [31:0]      ent_a   [DEPTH];
  logic [31:0]      ent_b   [DEPTH];
  logic [HW-1:0]    holdoff;

  logic             vld_p1;
  sqn_t             iss_sqn_p1;
  logic [TAG_W-1:0] iss_tag_p1;
  logic [1:0]       iss_op_p1;
  logic [31:0]      iss_a_p1;
  logic [31:0]      iss_b_p1;

  logic [CW-1:0]    cnt;
  logic             ready;
  logic [DEPTH-1:0] flush_mask;
  logic             found;
  logic [IW-1:0]    best;
  logic [IW-1:0]    free_idx;
  logic             do_issue;
  logic             enq;

  // Stage p0: occupancy, flush mask, oldest-entry selection, free-slot search
  always_comb begin
    cnt        = '0;
    flush_mask = '0;
    found      = 1'b0;
    best       = '0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt           = cnt + CW'(ent_vld[i]);
      flush_mask[i] = bus.IN_brTaken && younger(ent_sqn[i], bus.IN_brSqN);
      if (ent_vld[i] && !flush_mask[i] && (!found || older(ent_sqn[i], ent_sqn[best]))) begin
        found = 1'b1;
        best  = IW'(i);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_vld[i]) free_idx = IW'(i);
    end
  end

  assign ready    = (cnt != CW'(DEPTH));
  assign do_issue = !bus.IN_divBusy && (holdoff == '0) && found;
  assign enq      = bus.IN_valid && ready &&
                    !(bus.IN_brTaken && younger(bus.IN_sqN, bus.IN_brSqN));

  // Stage p1: queue control and issue registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld    <= '0;
      holdoff    <= '0;
      vld_p1     <= 1'b0;
      iss_sqn_p1 <= '0;
      iss_tag_p1 <= '0;
      iss_op_p1  <= '0;
      iss_a_p1   <= '0;
      iss_b_p1   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((do_issue && best == IW'(i)) || flush_mask[i]) ent_vld[i] <= 1'b0;
      end
      // The free slot is invalid, so enqueue never collides with an issue or flush of a live entry.
      if (enq) ent_vld[free_idx] <= 1'b1;
      vld_p1 <= do_issue;
      if (do_issue) begin
        iss_sqn_p1 <= ent_sqn[best];
        iss_tag_p1 <= ent_tag[best];
        iss_op_p1  <= ent_op[best];
        iss_a_p1   <= ent_a[best];
        iss_b_p1   <= ent_b[best];
        holdoff    <= HW'(HOLDOFF);
      end else if (holdoff != '0) begin
        holdoff <= holdoff - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_sqn[free_idx] <= bus.IN_sqN;
      ent_tag[free_idx] <= bus.IN_tagDst;
      ent_op[free_idx]  <= bus.IN_opcode;
      ent_a[free_idx]   <= bus.IN_srcA;
      ent_b[free_idx]   <= bus.IN_srcB;
    end
  end

  assign bus.OUT_ready     = ready;
  assign bus.OUT_count     = cnt;
  assign bus.OUT_issValid  = vld_p1;
  assign bus.OUT_issSqN    = iss_sqn_p1;
  assign bus.OUT_issTagDst = iss_tag_p1;
  assign bus.OUT_issOpcode = iss_op_p1;
  assign bus.OUT_issSrcA   = iss_a_p1;
  assign bus.OUT_issSrcB   = iss_b_p1;
endmodule

// File: tb/tb_div_issue_scheduler.sv
// Directed bench for div_issue_scheduler: reset, latency, ordering, full, flush, wrap, async reset.
module tb_div_issue_scheduler;
  localparam int DEPTH = 4;
  localparam int SQN_W = 7;
  localparam int TAG_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  div_issue_scheduler_if #(.DEPTH(DEPTH), .SQN_W(SQN_W), .TAG_W(TAG_W)) bus ();

  div_issue_scheduler #(.DEPTH(DEPTH), .SQN_W(SQN_W), .TAG_W(TAG_W), .HOLDOFF(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [SQN_W-1:0] s, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    bus.IN_valid  = v;
    bus.IN_sqN    = s;
    bus.IN_tagDst = TAG_W'(s + 7'd1);
    bus.IN_opcode = op;
    bus.IN_srcA   = a;
    bus.IN_srcB   = b;
  endtask

  initial begin
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    bus.IN_brTaken = 1'b0;
    bus.IN_brSqN   = '0;
    bus.IN_divBusy = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_issValid", 32'(bus.OUT_issValid), 0);
    chk("rst_count",    32'(bus.OUT_count), 0);
    chk("rst_ready",    32'(bus.OUT_ready), 1);
    chk("rst_issSrcA",  bus.OUT_issSrcA, 0);
    tick();
    tick();
    rst = 1'b1;

    // 1: idle latency, enqueue at edge N -> issue visible after edge N+1
    set_in(1'b1, 7'd5, 2'd1, 32'd100, 32'd7);
    tick();
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    chk("t1_count_after_enq", 32'(bus.OUT_count), 1);
    chk("t1_no_issue_yet",    32'(bus.OUT_issValid), 0);
    tick();
    chk("t1_issValid", 32'(bus.OUT_issValid), 1);
    chk("t1_issSqN",   32'(bus.OUT_issSqN), 5);
    chk("t1_issSrcA",  bus.OUT_issSrcA, 100);
    chk("t1_issSrcB",  bus.OUT_issSrcB, 7);
    chk("t1_issOp",    32'(bus.OUT_issOpcode), 1);
    chk("t1_issTag",   32'(bus.OUT_issTagDst), 6);
    chk("t1_count",    32'(bus.OUT_count), 0);
    tick();
    chk("t1_pulse",    32'(bus.OUT_issValid), 0);

    // 2: oldest-first order with hold-off spacing
    bus.IN_divBusy = 1'b1;
    set_in(1'b1, 7'd9, 2'd0, 32'd900, 32'd9);
    tick();
    set_in(1'b1, 7'd3, 2'd2, 32'd300, 32'd3);
    tick();
    set_in(1'b1, 7'd6, 2'd3, 32'd600, 32'd6);
    tick();
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    chk("t2_count3",    32'(bus.OUT_count), 3);
    chk("t2_busy_hold", 32'(bus.OUT_issValid), 0);
    bus.IN_divBusy = 1'b0;
    tick();
    chk("t2_first_sqN",  32'(bus.OUT_issSqN), 3);
    chk("t2_first_srcA", bus.OUT_issSrcA, 300);
    chk("t2_count2",     32'(bus.OUT_count), 2);
    tick();
    chk("t2_holdoff1", 32'(bus.OUT_issValid), 0);
    tick();
    chk("t2_holdoff2", 32'(bus.OUT_issValid), 0);
    tick();
    chk("t2_second_vld", 32'(bus.OUT_issValid), 1);
    chk("t2_second_sqN", 32'(bus.OUT_issSqN), 6);
    tick();
    tick();
    tick();
    chk("t2_third_sqN", 32'(bus.OUT_issSqN), 9);
    chk("t2_third_vld", 32'(bus.OUT_issValid), 1);
    chk("t2_count0",    32'(bus.OUT_count), 0);

    // 3: full queue rejects further input
    bus.IN_divBusy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, SQN_W'(20 + i), 2'd0, 32'(200 + i), 32'd1);
      tick();
    end
    chk("t3_count_full", 32'(bus.OUT_count), 4);
    chk("t3_not_ready",  32'(bus.OUT_ready), 0);
    set_in(1'b1, 7'd24, 2'd0, 32'd240, 32'd1);
    tick();
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    chk("t3_fifth_ignored", 32'(bus.OUT_count), 4);
    bus.IN_divBusy = 1'b0;
    tick();
    bus.IN_divBusy = 1'b1;
    chk("t3_issue_sqN", 32'(bus.OUT_issSqN), 20);
    chk("t3_count3",    32'(bus.OUT_count), 3);
    chk("t3_ready",     32'(bus.OUT_ready), 1);
    bus.IN_brTaken = 1'b1;
    bus.IN_brSqN   = 7'd19;
    tick();
    bus.IN_brTaken = 1'b0;
    chk("t3_flush_all", 32'(bus.OUT_count), 0);

    // 4: flush keeps older entries and drops a younger enqueue
    set_in(1'b1, 7'd10, 2'd0, 32'd1000, 32'd10);
    tick();
    set_in(1'b1, 7'd12, 2'd0, 32'd1200, 32'd12);
    tick();
    set_in(1'b1, 7'd14, 2'd0, 32'd1400, 32'd14);
    tick();
    set_in(1'b1, 7'd13, 2'd0, 32'd1300, 32'd13);
    bus.IN_brTaken = 1'b1;
    bus.IN_brSqN   = 7'd11;
    tick();
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    bus.IN_brTaken = 1'b0;
    chk("t4_count_after_flush", 32'(bus.OUT_count), 1);
    bus.IN_divBusy = 1'b0;
    tick();
    chk("t4_survivor_sqN",  32'(bus.OUT_issSqN), 10);
    chk("t4_survivor_srcA", bus.OUT_issSrcA, 1000);
    chk("t4_count0",        32'(bus.OUT_count), 0);

    // 5: sqN wrap, 126 is older than 2
    bus.IN_divBusy = 1'b1;
    set_in(1'b1, 7'd2, 2'd0, 32'd22, 32'd2);
    tick();
    set_in(1'b1, 7'd126, 2'd0, 32'd1260, 32'd126);
    tick();
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    bus.IN_divBusy = 1'b0;
    tick();
    chk("t5_wrap_first", 32'(bus.OUT_issSqN), 126);
    tick();
    tick();
    tick();
    chk("t5_wrap_second", 32'(bus.OUT_issSqN), 2);
    chk("t5_count0",      32'(bus.OUT_count), 0);

    // 6: asynchronous reset while an issue is on the outputs
    bus.IN_divBusy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, SQN_W'(40 + i), 2'd0, 32'(400 + i), 32'd1);
      tick();
    end
    set_in(1'b0, 7'd0, 2'd0, 32'd0, 32'd0);
    bus.IN_divBusy = 1'b0;
    tick();
    chk("t6_pre_vld",   32'(bus.OUT_issValid), 1);
    chk("t6_pre_count", 32'(bus.OUT_count), 3);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_vld",   32'(bus.OUT_issValid), 0);
    chk("t6_rst_count", 32'(bus.OUT_count), 0);
    chk("t6_rst_sqN",   32'(bus.OUT_issSqN), 0);
    tick();
    chk("t6_held_vld",  32'(bus.OUT_issValid), 0);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
